controle_pc: RTL and testbench

Next-address sequencer for the 26-bit program counter register.
- Computes the `endereco` value the PC loads on every clock edge.
- Owns the PC's `pc_reset` line.
- Sequences boot, normal fetch, stalls, halt/resume and interrupt entry/return (EPC save/restore).
- Sits between the decode/control unit and the PC register; the PC has no enable, so a hold is done by feeding `pc_atual` back.

---
 rtl/controle_pc.sv | 139 +++++++++++++
 tb/tb_controle_pc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_pc.sv
// Next-address sequencer for the program counter: boot hold, fetch flow,
// stalls, halt/resume and single-level interrupt entry/return with EPC.
module controle_pc #(
  parameter int                 ADDR_W      = 26,
  parameter logic [ADDR_W-1:0]  INT_VECTOR  = ADDR_W'(4),
  parameter int                 BOOT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_atual,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              interrupt,
  input  logic              eret,
  output logic [ADDR_W-1:0] endereco,
  output logic              pc_reset,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        estado
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              int_en_q, int_en_d;
  logic              pc_reset_q, pc_reset_d;

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] flow_addr;
  logic              take_int;

  assign seq_addr = pc_atual + ADDR_W'(1);
  assign br_addr  = seq_addr + {{(ADDR_W-16){branch_offset[15]}}, branch_offset};
  assign take_int = interrupt & int_en_q;

  // Address the running instruction stream would produce without an interrupt;
  // this is also what EPC captures when an interrupt preempts it.
  always_comb begin
    if (halt)              flow_addr = pc_atual;
    else if (eret)         flow_addr = epc_q;
    else if (jump_reg)     flow_addr = reg_target;
    else if (jump)         flow_addr = jump_target;
    else if (branch_taken) flow_addr = br_addr;
    else                   flow_addr = seq_addr;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    int_en_d   = int_en_q;
    pc_reset_d = pc_reset_q;
    endereco   = pc_atual;

    unique case (state_q)
      ST_BOOT: begin
        endereco = '0;
        if (cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          pc_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (stall) begin
          endereco = pc_atual;
        end else if (take_int) begin
          endereco = INT_VECTOR;
          epc_d    = flow_addr;
          int_en_d = 1'b0;
        end else begin
          endereco = flow_addr;
          if (halt)      state_d  = ST_HALT;
          else if (eret) int_en_d = 1'b1;
        end
      end

      ST_HALT: begin
        if (take_int) begin
          endereco = INT_VECTOR;
          epc_d    = seq_addr;
          int_en_d = 1'b0;
          state_d  = ST_RUN;
        end else if (resume) begin
          endereco = seq_addr;
          state_d  = ST_RUN;
        end
      end

      default: begin
        endereco = '0;
        state_d  = ST_BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      epc_q      <= '0;
      int_en_q   <= 1'b1;
      pc_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      epc_q      <= epc_d;
      int_en_q   <= int_en_d;
      pc_reset_q <= pc_reset_d;
    end
  end

  assign pc_reset = pc_reset_q;
  assign epc      = epc_q;
  assign estado   = state_q;

endmodule

// File: tb/tb_controle_pc.sv
// Self-checking bench for controle_pc: the bench owns the PC register and a
// behavioural model of the sequencing rules, compared every negedge.
module tb_controle_pc;

  localparam int              AW = 26;
  localparam logic [AW-1:0]   IV = 26'd4;
  localparam int              BC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_atual;
  logic          stall, halt, resume, branch_taken, jump, jump_reg, interrupt, eret;
  logic [15:0]   branch_offset;
  logic [AW-1:0] jump_target, reg_target;
  logic [AW-1:0] endereco, epc;
  logic          pc_reset;
  logic [1:0]    estado;

  controle_pc #(.ADDR_W(AW), .INT_VECTOR(IV), .BOOT_CYCLES(BC)) dut (
    .clock(clock), .reset(reset), .pc_atual(pc_atual),
    .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .reg_target(reg_target),
    .interrupt(interrupt), .eret(eret),
    .endereco(endereco), .pc_reset(pc_reset), .epc(epc), .estado(estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: 0 boot, 1 run, 2 halt.
  logic [1:0]    m_state;
  int            m_cnt;
  logic [AW-1:0] m_epc;
  logic          m_ie;
  logic          pc_load;
  logic [AW-1:0] pc_val;
  bit            cmp_en = 1'b0;

  function automatic logic [AW-1:0] wrap(input int v);
    return AW'(v);
  endfunction

  function automatic logic [AW-1:0] flow_target();
    int off;
    off = int'($signed(branch_offset));
    if (halt)         return pc_atual;
    if (eret)         return m_epc;
    if (jump_reg)     return reg_target;
    if (jump)         return jump_target;
    if (branch_taken) return wrap(int'(pc_atual) + 1 + off);
    return wrap(int'(pc_atual) + 1);
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    case (m_state)
      2'd1: begin
        if (stall)             return pc_atual;
        if (interrupt && m_ie) return IV;
        return flow_target();
      end
      2'd2: begin
        if (interrupt && m_ie) return IV;
        if (resume)            return wrap(int'(pc_atual) + 1);
        return pc_atual;
      end
      default: return '0;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= 2'd0;
      m_cnt   <= 0;
      m_epc   <= '0;
      m_ie    <= 1'b1;
    end else begin
      case (m_state)
        2'd0: if (m_cnt == BC - 1) m_state <= 2'd1; else m_cnt <= m_cnt + 1;
        2'd1: if (!stall) begin
          if (interrupt && m_ie) begin
            m_epc <= flow_target();
            m_ie  <= 1'b0;
          end else if (halt) m_state <= 2'd2;
          else if (eret)     m_ie    <= 1'b1;
        end
        2'd2: if (interrupt && m_ie) begin
          m_epc   <= wrap(int'(pc_atual) + 1);
          m_ie    <= 1'b0;
          m_state <= 2'd1;
        end else if (resume) m_state <= 2'd1;
        default: m_state <= 2'd0;
      endcase
    end
  end

  // The PC register the sequencer drives; the bench may preload it.
  always @(posedge clock)
    pc_atual <= pc_load ? pc_val : exp_addr();

  always @(negedge clock) begin
    if (cmp_en) begin
      check("estado",   32'(estado),   32'(m_state));
      check("pc_reset", 32'(pc_reset), 32'(m_state == 2'd0));
      check("epc",      32'(epc),      32'(m_epc));
      check("endereco", 32'(endereco), 32'(exp_addr()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; resume = 0; branch_taken = 0; branch_offset = '0;
    jump = 0; jump_target = '0; jump_reg = 0; reg_target = '0;
    interrupt = 0; eret = 0;
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    pc_load = 1'b1;
    pc_val  = v;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    pc_load = 1'b0;
    pc_val  = '0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("rst_estado",   32'(estado),   32'd0);
    check("rst_pc_reset", 32'(pc_reset), 32'd1);
    check("rst_epc",      32'(epc),      32'd0);
    check("rst_endereco", 32'(endereco), 32'd0);

    // Boot: pc_reset held for exactly BC edges after release.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < BC; i++) begin
      @(negedge clock);
      check("boot_pc_reset_hi", 32'(pc_reset), 32'd1);
    end
    @(negedge clock);
    check("boot_pc_reset_lo", 32'(pc_reset), 32'd0);
    check("boot_estado_run",  32'(estado),   32'd1);
    check("count_1", 32'(endereco), 32'd1);
    @(negedge clock);
    check("count_2", 32'(endereco), 32'd2);
    @(negedge clock);
    check("count_3", 32'(endereco), 32'd3);

    // Control flow.
    clear_inputs();
    set_pc(26'd10);
    branch_taken = 1; branch_offset = 16'hFFFD;
    @(negedge clock);
    check("branch_neg", 32'(endereco), 32'd8);
    tick();
    branch_offset = 16'd5;
    @(negedge clock);
    check("branch_pos", 32'(endereco), 32'd14);
    tick();
    jump = 1; jump_target = 26'd100;
    @(negedge clock);
    check("jump_over_branch", 32'(endereco), 32'd100);
    tick();
    jump_reg = 1; reg_target = 26'd200;
    @(negedge clock);
    check("jr_over_jump", 32'(endereco), 32'd200);
    clear_inputs();
    set_pc(26'h3FFFFFF);
    @(negedge clock);
    check("seq_wrap", 32'(endereco), 32'd0);

    // Stall masks interrupt and jump.
    clear_inputs();
    set_pc(26'd20);
    stall = 1; interrupt = 1; jump = 1; jump_target = 26'd77;
    @(negedge clock);
    check("stall_hold", 32'(endereco), 32'd20);
    check("stall_epc",  32'(epc),      32'd0);
    tick();
    @(negedge clock);
    check("stall_hold2", 32'(endereco), 32'd20);
    tick();
    stall = 0;
    @(negedge clock);
    check("int_after_stall", 32'(endereco), 32'd4);
    tick();
    @(negedge clock);
    check("int_epc_jump", 32'(epc), 32'd77);
    tick();
    clear_inputs();
    eret = 1;
    @(negedge clock);
    check("eret_to_77", 32'(endereco), 32'd77);
    tick();
    clear_inputs();

    // Interrupt entry, masking, return and re-entry.
    set_pc(26'd50);
    interrupt = 1;
    @(negedge clock);
    check("int_vec", 32'(endereco), 32'd4);
    tick();
    @(negedge clock);
    check("int_epc51",  32'(epc),      32'd51);
    check("int_masked", 32'(endereco), 32'd5);
    tick();
    eret = 1;
    @(negedge clock);
    check("eret_51", 32'(endereco), 32'd51);
    tick();
    eret = 0;
    @(negedge clock);
    check("int_reentry", 32'(endereco), 32'd4);
    tick();
    @(negedge clock);
    check("int_epc52", 32'(epc), 32'd52);
    tick();
    clear_inputs();
    eret = 1;
    @(negedge clock);
    check("eret_52", 32'(endereco), 32'd52);
    tick();
    clear_inputs();

    // Halt / resume.
    set_pc(26'd30);
    halt = 1;
    @(negedge clock);
    check("halt_hold", 32'(endereco), 32'd30);
    tick();
    halt = 0;
    for (int i = 0; i < 5; i++) begin
      stall = (i == 2);
      @(negedge clock);
      check("halted_estado", 32'(estado),   32'd2);
      check("halted_pc",     32'(endereco), 32'd30);
      tick();
    end
    stall = 0; resume = 1;
    @(negedge clock);
    check("resume_seq", 32'(endereco), 32'd31);
    tick();
    resume = 0;
    @(negedge clock);
    check("resume_estado", 32'(estado), 32'd1);

    clear_inputs();
    set_pc(26'd30);
    halt = 1;
    tick();
    halt = 0; resume = 1; interrupt = 1;
    @(negedge clock);
    check("halt_int_vec", 32'(endereco), 32'd4);
    tick();
    clear_inputs();
    @(negedge clock);
    check("halt_int_epc",    32'(epc),    32'd31);
    check("halt_int_estado", 32'(estado), 32'd1);

    // Asynchronous reset inside the handler, between clock edges.
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_estado",   32'(estado),   32'd0);
    check("async_pc_reset", 32'(pc_reset), 32'd1);
    check("async_epc",      32'(epc),      32'd0);
    check("async_endereco", 32'(endereco), 32'd0);
    tick();
    reset = 1'b1;
    repeat (BC + 2) @(negedge clock);
    check("reboot_estado",   32'(estado),   32'd1);
    check("reboot_pc_reset", 32'(pc_reset), 32'd0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
